// File: rtl/uart_control_receiver.sv
// UART receive controller: oversampled 8N1-style deserializer that hands complete
// frames to an RX FIFO and flags framing/overrun drops as one-cycle pulses.
module uart_control_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic                 full,
  output logic                 write,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 error_overrun,
  output logic                 error_framing,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 rx_prev_q, rx_prev_d;
  logic                 write_q, write_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;
  logic                 busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= {DATA_BITS{1'b0}};
      data_q     <= {DATA_BITS{1'b0}};
      rx_prev_q  <= 1'b1;
      write_q    <= 1'b0;
      overrun_q  <= 1'b0;
      framing_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      rx_prev_q  <= rx_prev_d;
      write_q    <= write_d;
      overrun_q  <= overrun_d;
      framing_q  <= framing_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; everything, including the edge-detect history, moves only on sample_tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    rx_prev_d  = rx_prev_q;
    write_d    = 1'b0;
    overrun_d  = 1'b0;
    framing_d  = 1'b0;

    if (sample_tick) begin
      rx_prev_d = rx_s_q;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s_q) begin
            state_d    = START;
            tick_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end

        START: begin
          if (tick_cnt_q == MID_TICK) begin
            if (!rx_s_q) begin
              state_d    = DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = 4'd0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            state_d = IDLE;
            // A low stop bit wins over a full FIFO.
            if (!rx_s_q) begin
              framing_d = 1'b1;
            end else if (full) begin
              overrun_d = 1'b1;
            end else begin
              write_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        default: begin
          state_d    = IDLE;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != IDLE);
  end

  assign write         = write_q;
  assign data_out      = data_q;
  assign error_overrun = overrun_q;
  assign error_framing = framing_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_control_receiver.sv
// Scoreboard bench for uart_control_receiver: stimulus queues expected pulses,
// a monitor pops and compares whenever write or an error pulse appears.
module tb_uart_control_receiver;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TDIV     = 3;
  localparam int BIT_CLKS = OS * TDIV;

  localparam int K_WRITE   = 0;
  localparam int K_OVERRUN = 1;
  localparam int K_FRAMING = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       sample_tick;
  logic       full;
  logic       write;
  logic [7:0] data_out;
  logic       error_overrun;
  logic       error_framing;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] last_data;

  always #5 clk = ~clk;

  uart_control_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .sample_tick  (sample_tick),
    .full         (full),
    .write        (write),
    .data_out     (data_out),
    .error_overrun(error_overrun),
    .error_framing(error_framing),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // sample_tick: one clk high out of every TDIV clks
  initial begin : tick_gen
    int ph;
    ph = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph == TDIV - 1) ? 0 : ph + 1;
      sample_tick = (ph == 0);
    end
  end

  initial begin : monitor
    int   kind;
    int   n;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (write || error_overrun || error_framing) begin
        n = int'(write) + int'(error_overrun) + int'(error_framing);
        chk("pulse_exclusive", n, 1);
        kind = write ? K_WRITE : (error_overrun ? K_OVERRUN : K_FRAMING);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d data_out %0h, expected no pulse", kind, data_out);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("pulse_data_out", {24'd0, data_out}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic expect_pulse(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    if (kind == K_WRITE) begin
      last_data = d;
    end
    e.data = last_data;
    sb.push_back(e);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic settle_and_check(input string tag);
    idle_bits(2);
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
    chk({tag, "_data_hold"}, {24'd0, data_out}, {24'd0, last_data});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, {31'd0, write}, 0);
    chk({tag, "_overrun"}, {31'd0, error_overrun}, 0);
    chk({tag, "_framing"}, {31'd0, error_framing}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_data_out"}, {24'd0, data_out}, 0);
  endtask

  initial begin : stimulus
    logic [7:0] d55;
    rx        = 1'b1;
    full      = 1'b0;
    reset     = 1'b1;
    last_data = 8'h00;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle_bits(2);

    // Plain frame
    expect_pulse(K_WRITE, 8'hA5);
    send_frame(8'hA5, 1'b1);
    settle_and_check("a5");

    // Start-bit glitch: low for 4 ticks, then high
    rx = 1'b0;
    repeat (3 * TDIV) @(negedge clk);
    chk("glitch_busy_high", {31'd0, busy}, 1);
    repeat (TDIV) @(negedge clk);
    rx = 1'b1;
    repeat (8 * TDIV) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 0);
    settle_and_check("glitch");

    // Framing error: low stop bit
    expect_pulse(K_FRAMING, 8'h00);
    send_frame(8'h3C, 1'b0);
    settle_and_check("framing");

    // Overrun, then normal frame once FIFO drains
    full = 1'b1;
    expect_pulse(K_OVERRUN, 8'h00);
    send_frame(8'h81, 1'b1);
    full = 1'b0;
    settle_and_check("overrun");
    expect_pulse(K_WRITE, 8'h7E);
    send_frame(8'h7E, 1'b1);
    settle_and_check("after_overrun");

    // Back-to-back frames with no idle gap
    expect_pulse(K_WRITE, 8'h00);
    expect_pulse(K_WRITE, 8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    settle_and_check("b2b");

    // Reset in the middle of bit 3 of 0x55
    d55 = 8'h55;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d55[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d55[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    last_data = 8'h00;
    reset = 1'b0;
    settle_and_check("post_reset");
    expect_pulse(K_WRITE, 8'h12);
    send_frame(8'h12, 1'b1);
    settle_and_check("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
